// File: rtl/phy_sync_pkg.sv
// rtl/phy_sync_pkg.sv - shared PHY sync symbols, byte width and lock-state encoding
package phy_sync_pkg;

  localparam int         PHY_BYTE_W = 8;
  localparam logic [7:0] COM        = 8'hBC;
  localparam logic [7:0] IDLE       = 8'h7C;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

  function automatic logic is_ctrl(input logic [PHY_BYTE_W-1:0] b);
    return (b == COM) || (b == IDLE);
  endfunction

endpackage

// File: rtl/rx_byte_framer.sv
// rtl/rx_byte_framer.sv - serial shift register and bit counter producing byte candidates
module rx_byte_framer
  import phy_sync_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  serial_i,
  input  logic                  align_i,
  output logic [PHY_BYTE_W-1:0] cand_o,
  output logic                  boundary_o
);

  // Only the seven older bits are stored; the newest bit is the live input.
  logic [PHY_BYTE_W-2:0] shift_q;
  logic [2:0]            bit_cnt_q;
  logic [2:0]            bit_cnt_d;

  assign cand_o     = {shift_q, serial_i};
  assign boundary_o = (bit_cnt_q == 3'd7);
  assign bit_cnt_d  = align_i ? 3'd0 : bit_cnt_q + 3'd1;

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shift_q   <= cand_o[PHY_BYTE_W-2:0];
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/rx_link_sync_ctrl.sv
// rtl/rx_link_sync_ctrl.sv - COM hunt, verify and lock FSM with framed byte qualification
module rx_link_sync_ctrl
  import phy_sync_pkg::*;
#(
  parameter int SYNC_COUNT = 4,
  parameter int GAP_LIMIT  = 16
) (
  input  logic                  clk_32f,
  input  logic                  rst,
  input  logic                  serial_in,
  output logic [PHY_BYTE_W-1:0] byte_out,
  output logic                  byte_strobe,
  output logic                  byte_valid,
  output logic                  active,
  output logic                  idle_out,
  output logic [1:0]            lock_state
);

  localparam logic [3:0] SYNC_N = SYNC_COUNT[3:0];
  localparam logic [7:0] GAP_N  = GAP_LIMIT[7:0];

  lock_state_e           state_q;
  logic [3:0]            com_cnt_q;
  logic [3:0]            com_cnt_d;
  logic [7:0]            gap_cnt_q;
  logic [7:0]            gap_cnt_d;
  logic [PHY_BYTE_W-1:0] byte_out_q;
  logic                  byte_strobe_q;
  logic                  byte_valid_q;
  logic                  active_q;
  logic                  idle_out_q;

  logic [PHY_BYTE_W-1:0] cand;
  logic                  boundary;
  logic                  is_com;

  // Bit counter is held at zero while hunting so the byte phase restarts on each COM match.
  rx_byte_framer u_framer (
    .clk_i      (clk_32f),
    .rst        (rst),
    .serial_i   (serial_in),
    .align_i    (state_q == HUNT),
    .cand_o     (cand),
    .boundary_o (boundary)
  );

  assign is_com    = (cand == COM);
  assign com_cnt_d = com_cnt_q + 4'd1;
  assign gap_cnt_d = gap_cnt_q + 8'd1;

  always_ff @(posedge clk_32f) begin
    if (!rst) begin
      state_q       <= HUNT;
      com_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      byte_out_q    <= '0;
      byte_strobe_q <= 1'b0;
      byte_valid_q  <= 1'b0;
      active_q      <= 1'b0;
      idle_out_q    <= 1'b0;
    end else begin
      byte_strobe_q <= 1'b0;
      case (state_q)
        HUNT: begin
          if (is_com) begin
            state_q   <= VERIFY;
            com_cnt_q <= 4'd1;
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (is_com) begin
              com_cnt_q <= com_cnt_d;
              if (com_cnt_d == SYNC_N) begin
                state_q   <= LOCKED;
                gap_cnt_q <= '0;
                active_q  <= 1'b1;
              end
            end else begin
              state_q   <= HUNT;
              com_cnt_q <= '0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            if (!is_com && (gap_cnt_d == GAP_N)) begin
              state_q      <= HUNT;
              com_cnt_q    <= '0;
              gap_cnt_q    <= '0;
              active_q     <= 1'b0;
              byte_valid_q <= 1'b0;
              idle_out_q   <= 1'b0;
            end else begin
              gap_cnt_q     <= is_com ? 8'd0 : gap_cnt_d;
              byte_out_q    <= cand;
              byte_strobe_q <= 1'b1;
              byte_valid_q  <= !is_ctrl(cand);
              idle_out_q    <= (cand == IDLE);
            end
          end
        end
        default: begin
          state_q   <= HUNT;
          com_cnt_q <= '0;
          active_q  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_out    = byte_out_q;
  assign byte_strobe = byte_strobe_q;
  assign byte_valid  = byte_valid_q;
  assign active      = active_q;
  assign idle_out    = idle_out_q;
  assign lock_state  = state_q;

endmodule

// File: tb/tb_rx_link_sync_ctrl.sv
// tb/tb_rx_link_sync_ctrl.sv - directed self-checking bench for rx_link_sync_ctrl
module tb_rx_link_sync_ctrl;

  logic       clk_32f = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b0;
  logic [7:0] byte_out;
  logic       byte_strobe;
  logic       byte_valid;
  logic       active;
  logic       idle_out;
  logic [1:0] lock_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_strobe = 0;
  int last_strobe_cyc = 0;
  int lock_cyc = 0;
  logic [7:0] last_byte = 8'h00;
  logic       last_valid = 1'b0;
  logic       last_idle = 1'b0;
  logic       saw_active = 1'b0;

  rx_link_sync_ctrl #(.SYNC_COUNT(4), .GAP_LIMIT(16)) dut (
    .clk_32f     (clk_32f),
    .rst         (rst),
    .serial_in   (serial_in),
    .byte_out    (byte_out),
    .byte_strobe (byte_strobe),
    .byte_valid  (byte_valid),
    .active      (active),
    .idle_out    (idle_out),
    .lock_state  (lock_state)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk_32f);
    #1;
    cyc++;
    if (active) saw_active = 1'b1;
    if (byte_strobe) begin
      n_strobe++;
      last_byte       = byte_out;
      last_valid      = byte_valid;
      last_idle       = idle_out;
      last_strobe_cyc = cyc;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    serial_in = 1'b0;
    repeat (2) @(posedge clk_32f);
    #1;
    rst = 1'b1;
  endtask

  task automatic lock_up();
    repeat (4) send_byte(8'hBC);
    lock_cyc = cyc;
  endtask

  initial begin
    logic [2:0] rbits;
    do_reset();
    chk("reset_outputs", {byte_out, byte_strobe, byte_valid, active, idle_out, lock_state}, 32'h0);

    // lock acquisition
    rbits = 3'($urandom_range(0, 7));
    for (int i = 2; i >= 0; i--) send_bit(rbits[i]);
    chk("hunt_before_com", lock_state, 32'd0);
    send_byte(8'hBC);
    chk("verify_after_bc1", lock_state, 32'd1);
    send_byte(8'hBC);
    send_byte(8'hBC);
    chk("verify_after_bc3", {active, lock_state}, {1'b0, 2'd1});
    send_byte(8'hBC);
    lock_cyc = cyc;
    chk("locked_after_bc4", {active, lock_state}, {1'b1, 2'd2});
    chk("no_strobe_lock_com", n_strobe, 32'd0);
    send_byte(8'h55);
    chk("first_strobe_count", n_strobe, 32'd1);
    chk("first_strobe_byte", {last_byte, last_valid}, {8'h55, 1'b1});
    chk("first_strobe_delay", last_strobe_cyc - lock_cyc, 32'd8);

    // verify failure
    do_reset();
    saw_active = 1'b0;
    send_byte(8'hBC);
    send_byte(8'hBC);
    chk("vf_verify", lock_state, 32'd1);
    send_byte(8'h3A);
    chk("vf_back_to_hunt", lock_state, 32'd0);
    chk("vf_never_active", saw_active, 32'd0);
    lock_up();
    chk("vf_relock", {active, lock_state}, {1'b1, 2'd2});

    // control qualification
    n_strobe = 0;
    send_byte(8'h7C);
    chk("ctl_idle", {last_byte, last_valid, last_idle, idle_out}, {8'h7C, 1'b0, 1'b1, 1'b1});
    send_byte(8'hBC);
    chk("ctl_com", {last_byte, last_valid, last_idle}, {8'hBC, 1'b0, 1'b0});
    send_byte(8'h12);
    chk("ctl_data", {last_byte, last_valid, last_idle}, {8'h12, 1'b1, 1'b0});
    chk("ctl_strobes", n_strobe, 32'd3);

    // gap loss
    do_reset();
    lock_up();
    n_strobe = 0;
    repeat (15) send_byte(8'hA5);
    chk("gap_15_locked", {active, lock_state}, {1'b1, 2'd2});
    chk("gap_15_strobes", n_strobe, 32'd15);
    send_byte(8'hA5);
    chk("gap_loss_state", {active, lock_state}, {1'b0, 2'd0});
    chk("gap_loss_strobes", n_strobe, 32'd15);
    chk("gap_loss_outputs", {byte_out, byte_valid, idle_out}, {8'hA5, 1'b0, 1'b0});

    // gap rescue
    do_reset();
    lock_up();
    n_strobe = 0;
    repeat (15) send_byte(8'hA5);
    send_byte(8'hBC);
    chk("rescue_com", {last_byte, last_valid, lock_state}, {8'hBC, 1'b0, 2'd2});
    repeat (15) send_byte(8'hA5);
    chk("rescue_held", {active, lock_state}, {1'b1, 2'd2});
    chk("rescue_strobes", n_strobe, 32'd31);

    // reset mid-operation
    do_reset();
    lock_up();
    send_byte(8'h55);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b0;
    @(posedge clk_32f);
    #1;
    chk("midreset_outputs", {byte_out, byte_strobe, byte_valid, active, idle_out, lock_state}, 32'h0);
    rst = 1'b1;
    repeat (3) send_byte(8'hBC);
    chk("midreset_not_locked", lock_state, 32'd1);
    send_byte(8'hBC);
    chk("midreset_relock", {active, lock_state}, {1'b1, 2'd2});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
